// File: rtl/core_reset_ctrl_if.sv
// Reset-request inputs and reset/status outputs of core_reset_ctrl.
// master drives the requests (board/JTAG side), slave is the sequencer.
interface core_reset_ctrl_if;
    logic       i_trstn;
    logic       i_btn_reset;
    logic       i_core_fault;
    logic       o_core_reset;
    logic [1:0] o_reset_cause;
    logic [7:0] o_reset_count;

    modport master (
        output i_trstn, i_btn_reset, i_core_fault,
        input  o_core_reset, o_reset_cause, o_reset_count
    );

    modport slave (
        input  i_trstn, i_btn_reset, i_core_fault,
        output o_core_reset, o_reset_cause, o_reset_count
    );
endinterface

// File: rtl/core_reset_ctrl.sv
// Core reset sequencer: POR, JTAG TRSTn, debounced button and optional fault restart feed one registered core reset.
// Optional feature macro: FAULT_RESTART_EN (restart the core after FAULT_CYCLES consecutive i_core_fault cycles).
//
// state | meaning
// HOLD  | core held in reset; down-counter runs toward release, reloaded while a request persists
// RUN   | core released; any request re-enters HOLD, bumping the count and latching the cause
module core_reset_ctrl #(
    parameter int POR_CYCLES    = 1024,
    parameter int HOLD_CYCLES   = 64,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 16,
    parameter int FAULT_CYCLES  = 4
) (
    input  logic             i_clk_25mhz,
    input  logic             i_resetn,
    core_reset_ctrl_if.slave bus
);
    localparam int CNT_W = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
    localparam int FLT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] POR_LOAD  = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [1:0] CAUSE_POR   = 2'd0;
    localparam logic [1:0] CAUSE_JTAG  = 2'd1;
    localparam logic [1:0] CAUSE_BTN   = 2'd2;
    localparam logic [1:0] CAUSE_FAULT = 2'd3;

    typedef enum logic {HOLD = 1'b0, RUN = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             cause_q, cause_d;
    logic [7:0]             count_q, count_d;
    logic                   core_reset_q;
    logic [SYNC_STAGES-1:0] trstn_sync_q;
    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic [FLT_W-1:0]       flt_cnt_q;
    logic                   btn_filt_q;
    logic                   jtag_req;
    logic                   btn_req;
    logic                   fault_req;
    logic                   req;

    // Synchronizers idle at the "no request" level so reset release never looks like a request.
    always_ff @(posedge i_clk_25mhz or negedge i_resetn) begin
        if (!i_resetn) begin
            trstn_sync_q <= '1;
            btn_sync_q   <= '0;
        end else begin
            trstn_sync_q <= {trstn_sync_q[SYNC_STAGES-2:0], bus.i_trstn};
            btn_sync_q   <= {btn_sync_q[SYNC_STAGES-2:0], bus.i_btn_reset};
        end
    end

    always_ff @(posedge i_clk_25mhz or negedge i_resetn) begin
        if (!i_resetn) begin
            flt_cnt_q  <= '0;
            btn_filt_q <= 1'b0;
        end else if (btn_sync_q[SYNC_STAGES-1] == btn_filt_q) begin
            flt_cnt_q <= '0;
        end else if (flt_cnt_q == FLT_W'(FILTER_CYCLES - 1)) begin
            flt_cnt_q  <= '0;
            btn_filt_q <= ~btn_filt_q;
        end else begin
            flt_cnt_q <= flt_cnt_q + FLT_W'(1);
        end
    end

    assign jtag_req = ~trstn_sync_q[SYNC_STAGES-1];
    assign btn_req  = btn_filt_q;

`ifdef FAULT_RESTART_EN
    localparam int FC_W = $clog2(FAULT_CYCLES + 1);
    logic [FC_W-1:0] fault_cnt_q;

    assign fault_req = (state_q == RUN) && bus.i_core_fault &&
                       (fault_cnt_q == FC_W'(FAULT_CYCLES - 1));

    always_ff @(posedge i_clk_25mhz or negedge i_resetn) begin
        if (!i_resetn) begin
            fault_cnt_q <= '0;
        end else if (state_q != RUN || !bus.i_core_fault || fault_req) begin
            fault_cnt_q <= '0;
        end else begin
            fault_cnt_q <= fault_cnt_q + FC_W'(1);
        end
    end
`else
    logic unused_core_fault;
    assign unused_core_fault = bus.i_core_fault;
    assign fault_req         = 1'b0;
`endif

    assign req = jtag_req | btn_req | fault_req;

    always_ff @(posedge i_clk_25mhz or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q      <= HOLD;
            cnt_q        <= POR_LOAD;
            cause_q      <= CAUSE_POR;
            count_q      <= '0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cause_q      <= cause_d;
            count_q      <= count_d;
            core_reset_q <= (state_d == HOLD);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        count_d = count_q;
        unique case (state_q)
            RUN: begin
                if (req) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                    if (count_q != 8'hFF) count_d = count_q + 8'd1;
                    if (jtag_req)     cause_d = CAUSE_JTAG;
                    else if (btn_req) cause_d = CAUSE_BTN;
                    else              cause_d = CAUSE_FAULT;
                end
            end
            HOLD: begin
                // A persisting request keeps the timer topped up, never shortening a longer POR hold.
                if (req) begin
                    if (cnt_q < HOLD_LOAD) cnt_d = HOLD_LOAD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = HOLD;
        endcase
    end

    assign bus.o_core_reset  = core_reset_q;
    assign bus.o_reset_cause = cause_q;
    assign bus.o_reset_count = count_q;
endmodule
